multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the multi-cycle RV32I datapath: shared instr/data memory, IR, old-PC/data/ALU-out regs.
//  Replaces the single-cycle opcode lookup with per-state control strobes. Supports lw, sw, R-type, I-type ALU, beq, jal.
//  Contains an ALU decoder sub-module that drives alu_ctrl.
// PARAMETERS
//  none. Opcodes, state encodings and select encodings are constants in rv_ctrl_pkg.
// PORTS
//  clk           in   1  single clock; all state updates on posedge
//  rst_n         in   1  reset; synchronous, active-low
//  opcode        in   7  IR[6:0]; sampled only in DECODE
//  funct3        in   3  IR[14:12]
//  funct7b5      in   1  IR[30]
//  zero          in   1  ALU zero flag
//  mem_ready     in   1  memory access complete (used only with MC_CTRL_MEM_WAIT_EN)
//  pc_wren       out  1  PC load = pc_update | (branch & zero)
//  adr_src       out  1  mem address: 0=PC, 1=result
//  mem_wren      out  1  data memory write strobe
//  ir_wren       out  1  IR and old-PC load
//  regfile_wren  out  1  register file write
//  result_sel    out  2  00=ALU-out reg, 01=mem data reg, 10=ALU result (combinational)
//  alu_asel      out  2  00=PC, 01=old PC, 10=rs1 reg
//  alu_bsel      out  2  00=rs2 reg, 01=ext imm, 10=const 4
//  ximm_sel      out  2  00=I, 01=S, 10=B, 11=J; decoded from opcode, combinational
//  alu_ctrl      out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_instr out  1  one-cycle pulse in DECODE when opcode unsupported
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
//  Transitions:
//   FETCH->DECODE.
//   DECODE by opcode: lw/sw->MEMADR; R->EXECR; I->EXECI; beq->BEQ; jal->JAL; other->FETCH with illegal_instr=1.
//   MEMADR: lw->MEMREAD, sw->MEMWRITE. MEMREAD->MEMWB. EXECR/EXECI/JAL->ALUWB.
//   MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
//  Strobes (anything not listed is 0; alu_op 00=add, 01=sub, 10=funct):
//   FETCH    : ir_wren=1, adr_src=0, asel=00, bsel=10, op=00, result=10, pc_update=1
//   DECODE   : asel=01, bsel=01, op=00 (branch/jump target -> ALU-out)
//   MEMADR   : asel=10, bsel=01, op=00
//   MEMREAD  : adr_src=1, result=00
//   MEMWRITE : adr_src=1, result=00, mem_wren=1
//   MEMWB    : result=01, regfile_wren=1
//   EXECR    : asel=10, bsel=00, op=10
//   EXECI    : asel=10, bsel=01, op=10
//   ALUWB    : result=00, regfile_wren=1
//   BEQ      : asel=10, bsel=00, op=01, result=00, branch=1
//   JAL      : asel=01, bsel=10, op=00, result=00, pc_update=1
//  Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
//  Outputs are a pure function of state, except pc_wren (uses zero), ximm_sel and alu_ctrl.
//  Reset: while rst_n=0, state<=FETCH on each posedge and every write strobe (pc/ir/mem/regfile) is forced 0.
//   First FETCH strobes assert on the first cycle rst_n=1. Reset mid-instruction abandons it with no partial writes.
//  alu_ctrl: op 00->add, op 01->sub. op 10: funct3 000 -> sub if funct7b5&opcode[5], else add;
//   010->slt, 110->or, 111->and; other->add.
//  unknown opcode: ximm_sel=00 and no write strobe asserts after DECODE.
// CONFIGURATION
//  MC_CTRL_MEM_WAIT_EN defined:
//   FETCH, MEMREAD and MEMWRITE hold state until mem_ready=1.
//   ir_wren/pc_wren/mem_wren assert only in the cycle where mem_ready=1 (ready-qualified, so no double update).
//  Not defined: mem_ready is ignored; every state lasts exactly one cycle.
// STRUCTURE
//  rv_ctrl_pkg:
//   opcode localparams (lw, sw, R, I, beq, jal)
//   typedef enum logic [3:0] mc_state_t
//   typedef enum for result_sel/alu_asel/alu_bsel/ximm_sel encodings
//   ALU op and ALU ctrl codes
//  Sub-module alu_decoder (alu_op, funct3, funct7b5, op5 -> alu_ctrl), instantiated once.
//  FSM and strobe decode stay in this module.
// TESTING
//  1. Reset held 3 cycles, release, opcode=0000011 -> FETCH: ir_wren=1, pc_wren=1; 0 writes during reset.
//  2. lw (0000011): states F,D,MEMADR,MEMREAD,MEMWB; regfile_wren=1 only in cycle 5, result_sel=01.
//  3. sw (0100011): mem_wren=1 only in cycle 4, adr_src=1, ximm_sel=01; regfile_wren stays 0.
//  4. R-type sub (funct3=000, funct7b5=1) -> alu_ctrl=001 in EXECR; I-type addi same funct7b5 -> 000.
//  5. beq, zero=1 -> pc_wren=1 in cycle 3, back in FETCH cycle 4; zero=0 -> pc_wren=0.
//  6. opcode=1111111 -> illegal_instr pulse in DECODE, FETCH next. rst_n=0 mid-lw (MEMREAD) -> FETCH, no regfile write.
//  7. With MC_CTRL_MEM_WAIT_EN: mem_ready=0 for 2 cycles in FETCH -> state holds; single ir_wren when ready=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select encodings, ALU op/ctrl codes and the per-state strobe bundle.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
   } mc_state_t;

   typedef enum logic [1:0] {
      RES_ALUOUT  = 2'b00,
      RES_MEMDATA = 2'b01,
      RES_ALU     = 2'b10
   } result_sel_t;

   typedef enum logic [1:0] {
      ASEL_PC    = 2'b00,
      ASEL_OLDPC = 2'b01,
      ASEL_RS1   = 2'b10
   } asel_t;

   typedef enum logic [1:0] {
      BSEL_RS2  = 2'b00,
      BSEL_IMM  = 2'b01,
      BSEL_FOUR = 2'b10
   } bsel_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } ximm_sel_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic        ir_wren;
      logic        adr_src;
      logic        mem_wren;
      logic        regfile_wren;
      logic        pc_update;
      logic        branch;
      result_sel_t result;
      asel_t       asel;
      bsel_t       bsel;
      alu_op_t     op;
   } strobes_t;

   function automatic logic is_supported(input logic [6:0] op);
      return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface mc_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_wren;
   logic       adr_src;
   logic       mem_wren;
   logic       ir_wren;
   logic       regfile_wren;
   logic [1:0] result_sel;
   logic [1:0] alu_asel;
   logic [1:0] alu_bsel;
   logic [1:0] ximm_sel;
   logic [2:0] alu_ctrl;
   logic       illegal_instr;

   modport ctrl (
      input  opcode, funct3, funct7b5, zero, mem_ready,
      output pc_wren, adr_src, mem_wren, ir_wren, regfile_wren, result_sel,
             alu_asel, alu_bsel, ximm_sel, alu_ctrl, illegal_instr
   );

   modport dp (
      output opcode, funct3, funct7b5, zero, mem_ready,
      input  pc_wren, adr_src, mem_wren, ir_wren, regfile_wren, result_sel,
             alu_asel, alu_bsel, ximm_sel, alu_ctrl, illegal_instr
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALU op plus funct3/funct7b5/opcode[5] to alu_ctrl.
module alu_decoder
   import rv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only means sub for R-type; addi reuses that bit as immediate
               3'b000:  alu_ctrl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multi-cycle RV32I datapath (lw, sw, R, I, beq, jal).
// Define MC_CTRL_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_controller
   import rv_ctrl_pkg::*;
(
   input logic  clk,
   input logic  rst_n,
   mc_ctrl_if.ctrl bus
);

   mc_state_t  state;
   strobes_t   strb;
   logic       is_store;
   logic       ready;
   logic       gate;
   ximm_sel_t  ximm;

   function automatic mc_state_t next_state(input mc_state_t s, input logic [6:0] op,
                                            input logic st, input logic rdy);
      mc_state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: n = S_MEMADR;
               OP_R:         n = S_EXECR;
               OP_I:         n = S_EXECI;
               OP_BEQ:       n = S_BEQ;
               OP_JAL:       n = S_JAL;
               default:      n = S_FETCH;
            endcase
         end
         S_MEMADR:   n = st ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
         S_EXECR, S_EXECI, S_JAL: n = S_ALUWB;
         default:    n = S_FETCH;
      endcase
      return n;
   endfunction

   function automatic strobes_t strobes_of(input mc_state_t s);
      strobes_t t;
      t = '0;
      case (s)
         S_FETCH: begin
            t.ir_wren = 1'b1;  t.pc_update = 1'b1;
            t.bsel = BSEL_FOUR; t.result = RES_ALU;
         end
         S_DECODE:   begin t.asel = ASEL_OLDPC; t.bsel = BSEL_IMM; end
         S_MEMADR:   begin t.asel = ASEL_RS1;   t.bsel = BSEL_IMM; end
         S_MEMREAD:  t.adr_src = 1'b1;
         S_MEMWRITE: begin t.adr_src = 1'b1; t.mem_wren = 1'b1; end
         S_MEMWB:    begin t.result = RES_MEMDATA; t.regfile_wren = 1'b1; end
         S_EXECR:    begin t.asel = ASEL_RS1; t.bsel = BSEL_RS2; t.op = ALUOP_FUNCT; end
         S_EXECI:    begin t.asel = ASEL_RS1; t.bsel = BSEL_IMM; t.op = ALUOP_FUNCT; end
         S_ALUWB:    t.regfile_wren = 1'b1;
         S_BEQ: begin
            t.asel = ASEL_RS1; t.bsel = BSEL_RS2; t.op = ALUOP_SUB; t.branch = 1'b1;
         end
         S_JAL: begin
            t.asel = ASEL_OLDPC; t.bsel = BSEL_FOUR; t.pc_update = 1'b1;
         end
         default: t = '0;
      endcase
      return t;
   endfunction

`ifdef MC_CTRL_MEM_WAIT_EN
   assign ready = bus.mem_ready;
   // Qualify the memory-side writes so a stalled cycle never double-updates IR/PC/memory
   assign gate  = (state == S_FETCH || state == S_MEMWRITE) ? bus.mem_ready : 1'b1;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign ready = 1'b1;
   assign gate  = 1'b1;
`endif

   // Strobes are registered from the next state so they are valid from the first cycle of each state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_FETCH;
         strb     <= strobes_of(S_FETCH);
         is_store <= 1'b0;
      end else begin
         state <= next_state(state, bus.opcode, is_store, ready);
         strb  <= strobes_of(next_state(state, bus.opcode, is_store, ready));
         if (state == S_DECODE) is_store <= (bus.opcode == OP_SW);
      end
   end

   always_comb begin
      case (bus.opcode)
         OP_SW:   ximm = IMM_S;
         OP_BEQ:  ximm = IMM_B;
         OP_JAL:  ximm = IMM_J;
         default: ximm = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op   (strb.op),
      .funct3   (bus.funct3),
      .funct7b5 (bus.funct7b5),
      .op5      (bus.opcode[5]),
      .alu_ctrl (bus.alu_ctrl)
   );

   // Write strobes are held low combinationally while reset is asserted
   assign bus.ir_wren       = strb.ir_wren & gate & rst_n;
   assign bus.mem_wren      = strb.mem_wren & gate & rst_n;
   assign bus.regfile_wren  = strb.regfile_wren & rst_n;
   assign bus.pc_wren       = ((strb.pc_update & gate) | (strb.branch & bus.zero)) & rst_n;
   assign bus.adr_src       = strb.adr_src;
   assign bus.result_sel    = strb.result;
   assign bus.alu_asel      = strb.asel;
   assign bus.alu_bsel      = strb.bsel;
   assign bus.ximm_sel      = ximm;
   assign bus.illegal_instr = (state == S_DECODE) & ~is_supported(bus.opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass = 0;
   string plan[$];
   logic [6:0] opc_pool [9];

   mc_ctrl_if ifc ();

   multicycle_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
   endtask

   function automatic logic [16:0] observe();
      return {ifc.illegal_instr, ifc.ir_wren, ifc.pc_wren, ifc.mem_wren, ifc.regfile_wren,
              ifc.adr_src, ifc.result_sel, ifc.alu_asel, ifc.alu_bsel, ifc.ximm_sel,
              ifc.alu_ctrl};
   endfunction

   // Operation an R/I instruction asks the ALU for
   function automatic logic [2:0] exec_alu(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic f7);
      case (f3)
         3'd0:    return (opc == RT && f7) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [16:0] model(input string ph, input logic [6:0] opc,
                                         input logic [2:0] f3, input logic f7,
                                         input logic z, input logic rdy);
      logic ill, ir, pc, mem, rf, adr;
      logic [1:0] res, asel, bsel, xi;
      logic [2:0] alu;
      {ill, ir, pc, mem, rf, adr} = 6'b0;
      res = 2'd0; asel = 2'd0; bsel = 2'd0; alu = 3'd0;
      xi = (opc == SW) ? 2'd1 : (opc == BEQ) ? 2'd2 : (opc == JAL) ? 2'd3 : 2'd0;
      case (ph)
         "F":   begin ir = rdy; pc = rdy; bsel = 2'd2; res = 2'd2; end
         "D":   begin asel = 2'd1; bsel = 2'd1;
                      ill = !(opc inside {LW, SW, RT, IT, BEQ, JAL}); end
         "MA":  begin asel = 2'd2; bsel = 2'd1; end
         "MR":  adr = 1'b1;
         "MW":  begin adr = 1'b1; mem = rdy; end
         "MWB": begin res = 2'd1; rf = 1'b1; end
         "XR":  begin asel = 2'd2; bsel = 2'd0; alu = exec_alu(opc, f3, f7); end
         "XI":  begin asel = 2'd2; bsel = 2'd1; alu = exec_alu(opc, f3, f7); end
         "AWB": rf = 1'b1;
         "BQ":  begin asel = 2'd2; alu = 3'b001; pc = z; end
         "J":   begin asel = 2'd1; bsel = 2'd2; pc = 1'b1; end
         default: ;
      endcase
      return {ill, ir, pc, mem, rf, adr, res, asel, bsel, xi, alu};
   endfunction

   task automatic plan_for(input logic [6:0] opc);
      case (opc)
         LW:      plan = '{"F", "D", "MA", "MR", "MWB"};
         SW:      plan = '{"F", "D", "MA", "MW"};
         RT:      plan = '{"F", "D", "XR", "AWB"};
         IT:      plan = '{"F", "D", "XI", "AWB"};
         BEQ:     plan = '{"F", "D", "BQ"};
         JAL:     plan = '{"F", "D", "J", "AWB"};
         default: plan = '{"F", "D"};
      endcase
   endtask

   // zmode <0: random zero each cycle; abort_at: phase index at which reset is asserted
   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input int zmode, input int abort_at, input int fwait);
      plan_for(opc);
      for (int i = 0; i < plan.size(); i++) begin
         string ph;
         int    waits;
         bit    memph;
         ph = plan[i];
         waits = 0;
         memph = (ph == "F" || ph == "MR" || ph == "MW");
`ifdef MC_CTRL_MEM_WAIT_EN
         if (memph) waits = (fwait >= 0 && i == 0) ? fwait : int'($urandom_range(0, 2));
`else
         if (memph && fwait > 0) waits = 0;
`endif
         for (int w = 0; w <= waits; w++) begin
            logic z, rdy;
            @(negedge clk);
            ifc.opcode = opc;
            ifc.funct3 = f3;
            ifc.funct7b5 = f7;
            z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            ifc.zero = z;
`ifdef MC_CTRL_MEM_WAIT_EN
            rdy = (w == waits);
            ifc.mem_ready = rdy;
`else
            rdy = 1'b1;
            ifc.mem_ready = 1'($urandom);
`endif
            if (i == abort_at) begin
               rst_n = 1'b0;
               #1;
               check($sformatf("op%02h:%s:rst_writes", opc, ph),
                     {13'd0, ifc.ir_wren, ifc.pc_wren, ifc.mem_wren, ifc.regfile_wren}, 17'd0);
               return;
            end
            rst_n = 1'b1;
            #1;
            check($sformatf("op%02h:%s", opc, ph), observe(), model(ph, opc, f3, f7, z, rdy));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      opc_pool = '{LW, SW, RT, IT, BEQ, JAL, 7'h7f, 7'h37, 7'h67};
      rst_n = 1'b0;
      ifc.opcode = LW;
      ifc.funct3 = 3'b010;
      ifc.funct7b5 = 1'b0;
      ifc.zero = 1'b1;
      ifc.mem_ready = 1'b1;

      repeat (3) begin
         @(negedge clk);
         #1;
         check("reset_writes", {13'd0, ifc.ir_wren, ifc.pc_wren, ifc.mem_wren, ifc.regfile_wren},
               17'd0);
      end

      run_instr(LW,  3'b010, 1'b0, -1, -1, -1);
      run_instr(SW,  3'b010, 1'b0, -1, -1, -1);
      run_instr(RT,  3'b000, 1'b1, -1, -1, -1);
      run_instr(IT,  3'b000, 1'b1, -1, -1, -1);
      run_instr(BEQ, 3'b000, 1'b0,  1, -1, -1);
      run_instr(BEQ, 3'b000, 1'b0,  0, -1, -1);
      run_instr(7'h7f, 3'b000, 1'b0, -1, -1, -1);
      run_instr(LW,  3'b010, 1'b0, -1,  3, -1);
      run_instr(JAL, 3'b000, 1'b0, -1, -1, -1);
`ifdef MC_CTRL_MEM_WAIT_EN
      run_instr(RT,  3'b111, 1'b0, -1, -1, 2);
`endif

      repeat (80) begin
         logic [6:0] opc;
         int ab;
         opc = opc_pool[$urandom_range(0, 8)];
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(opc, 3'($urandom), 1'($urandom), -1, ab, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
